// File: rtl/matrix_acc_drain_pkg.sv
// Shared constants and state encoding for the matrix accumulator drain block.
package matrix_acc_drain_pkg;

  localparam int N_LINES = 4;
  localparam int LINE_W  = 32;
  localparam int LANE_W  = 8;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/matrix_acc_drain_if.sv
// Valid/ready stream carrying accumulator lines out of the drain block.
interface matrix_acc_drain_if;
  import matrix_acc_drain_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [LINE_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_idx, out_last,
    output out_ready
  );

endinterface

// File: rtl/matrix_acc_drain.sv
// Accumulator line store with a serial valid/ready drain port.
// Build option: MATRIX_ACC_CLR_ON_DRAIN_EN zeroes the lines when a drain completes.
//
// state | meaning
// IDLE  | lines accept writes/clears, stream idle
// DRAIN | lines frozen, one line per handshake on the stream
module matrix_acc_drain
  import matrix_acc_drain_pkg::*;
#(
  parameter int N_LINES = matrix_acc_drain_pkg::N_LINES,
  parameter int LINE_W  = matrix_acc_drain_pkg::LINE_W
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           acc_we,
  input  logic [N_LINES-1:0][LINE_W-1:0] acc_wdata,
  input  logic                           acc_clr,
  output logic [N_LINES-1:0][LINE_W-1:0] acc_lines,
  input  logic                           drain_start,
  output logic                           drain_busy,
  output logic                           drain_done,
  matrix_acc_drain_if.master             drn
);

  state_t                         state, state_next;
  logic [N_LINES-1:0][LINE_W-1:0] lines, lines_next;
  logic [IDX_W-1:0]               idx, idx_next;
  logic [LINE_W-1:0]              data, data_next;
  logic                           done_next;
  logic                           handshake;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lines      <= '0;
      idx        <= '0;
      data       <= '0;
      drain_done <= 1'b0;
    end else begin
      lines      <= lines_next;
      idx        <= idx_next;
      data       <= data_next;
      drain_done <= done_next;
    end
  end

  assign handshake = (state == DRAIN) && drn.out_ready;

  always_comb begin
    state_next = state;
    lines_next = lines;
    idx_next   = idx;
    data_next  = data;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (acc_clr) begin
          lines_next = '0;
        end else begin
          if (acc_we) lines_next = acc_wdata;
          // a same-cycle write is visible to the first drained line
          if (drain_start) begin
            state_next = DRAIN;
            idx_next   = '0;
            data_next  = lines_next[0];
          end
        end
      end
      DRAIN: begin
        if (acc_clr) begin
          state_next = IDLE;
          lines_next = '0;
          idx_next   = '0;
          data_next  = '0;
        end else if (handshake) begin
          if (idx == IDX_W'(N_LINES - 1)) begin
            state_next = IDLE;
            idx_next   = '0;
            data_next  = '0;
            done_next  = 1'b1;
`ifdef MATRIX_ACC_CLR_ON_DRAIN_EN
            lines_next = '0;
`else
            lines_next = lines;
`endif
          end else begin
            idx_next  = idx + 1'b1;
            data_next = lines[idx + 1'b1];
          end
        end
      end
    endcase
  end

  assign acc_lines     = lines;
  assign drain_busy    = (state == DRAIN);
  assign drn.out_valid = (state == DRAIN);
  assign drn.out_data  = data;
  assign drn.out_idx   = idx;
  assign drn.out_last  = (state == DRAIN) && (idx == IDX_W'(N_LINES - 1));

endmodule

// File: doc/matrix_acc_drain.md
MATRIX_ACC_DRAIN -- requirements
Module: matrix_acc_drain

Interface
REQ-001 SHALL have parameter N_LINES, default 4: number of accumulator lines; fixed at 4 in this release.
REQ-002 SHALL have parameter LINE_W, default 32: line width, packed as four 8-bit lanes.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rstn, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port acc_we, input, 1: load all four accumulator lines from the update bus.
REQ-006 SHALL have port acc_wdata, input, 4x32: new line values from the matrix multiply unit, index 0..3.
REQ-007 SHALL have port acc_clr, input, 1: zero all lines.
REQ-008 SHALL have port acc_lines, output, 4x32: current accumulator contents, fed back as M to the multiply unit.
REQ-009 SHALL have port drain_start, input, 1: request serial readout of all lines.
REQ-010 SHALL have port drain_busy, output, 1: high while in DRAIN.
REQ-011 SHALL have port out_valid, output, 1: out_data holds a line.
REQ-012 SHALL have port out_ready, input, 1: the consumer accepts the line.
REQ-013 SHALL have port out_data, output, 32: the line being drained.
REQ-014 SHALL have port out_idx, output, 2: index of the line on out_data.
REQ-015 SHALL have port out_last, output, 1: out_idx equals 3.
REQ-016 SHALL have port drain_done, output, 1: one-cycle pulse after the final handshake.

Function
REQ-017 SHALL implement states IDLE and DRAIN.
REQ-018 SHALL, in IDLE with acc_we=1, register all four acc_wdata lines into acc_lines on the next clock edge.
REQ-019 SHALL give acc_clr priority over acc_we; lines are zeroed on the next edge.
REQ-020 SHALL, in IDLE with drain_start=1, enter DRAIN on the next edge with out_valid=1, out_idx=0, out_data=line0.
REQ-021 SHALL, when acc_we and drain_start are both high in IDLE, apply the write first; line0 of the new data is driven in the first DRAIN cycle.
REQ-022 SHALL advance out_idx by 1 on each cycle where out_valid and out_ready are both high.
REQ-023 SHALL sustain one line per cycle while out_ready is held high (4 lines in 4 cycles).
REQ-024 SHALL hold out_data, out_idx and out_last stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, on a handshake with out_last=1, return to IDLE next edge with out_valid=0, and pulse drain_done high for exactly that cycle.
REQ-026 SHALL ignore acc_we while in DRAIN (lines unchanged) and ignore drain_start while in DRAIN.
REQ-027 SHALL, on acc_clr in DRAIN, abort: next edge IDLE, out_valid=0, lines zeroed, no drain_done.
REQ-028 SHALL make out_data a registered output that is zero whenever out_valid=0.
REQ-029 SHALL drive acc_lines directly from the line registers with no added latency.

Reset
REQ-030 SHALL, on rstn low, asynchronously set state to IDLE, all lines to 0, out_valid=0, out_idx=0, out_data=0, out_last=0, drain_busy=0, drain_done=0.
REQ-031 SHALL, on reset mid-drain, drop out_valid immediately and emit no drain_done.

Configuration
REQ-032 SHALL, with MATRIX_ACC_CLR_ON_DRAIN_EN defined, zero all lines on the same edge as drain_done, so the next multiply accumulates from zero.
REQ-033 SHALL, without MATRIX_ACC_CLR_ON_DRAIN_EN, retain line contents after a drain.

Structure
REQ-034 SHALL place N_LINES, LINE_W, the state encoding (IDLE=0, DRAIN=1) and the lane width (8) in the shared matrix package.
REQ-035 SHALL be a single module with no sub-modules; the line store and the drain FSM are inline.

Verification
REQ-036 SHALL verify: reset, acc_we with lines {0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D} -> acc_lines match next cycle; all outputs 0 during reset.
REQ-037 SHALL verify: drain_start with out_ready=1 held -> idx 0,1,2,3 on consecutive cycles, out_last on idx 3, drain_done 1 cycle later, out_valid low.
REQ-038 SHALL verify: out_ready=0 for 3 cycles at idx 1 -> out_data=0x08070605 held stable, no advance, then resumes.
REQ-039 SHALL verify: acc_we=1 with wdata 0xFFFFFFFF during DRAIN -> lines unchanged; same-cycle acc_we+drain_start in IDLE -> first drained line is the new line0.
REQ-040 SHALL verify: acc_clr at idx 2 -> out_valid 0 next cycle, acc_lines all 0, drain_done never pulses.
REQ-041 SHALL verify: build with and without MATRIX_ACC_CLR_ON_DRAIN_EN -> acc_lines are 0, or retain the loaded values, in the cycle after drain_done.
